// File: rtl/panel_alarm_ctr.sv
// -----------------------------------------------------------------------------
// panel_alarm_ctr
//
// Front-panel alarm front-end. Each raw alarm source is synchronised, then
// glitch-filtered, then latched into a sticky flag. The sticky flags drive the
// panel alarm LED:
//   - steady lit while any critical source is latched,
//   - blinking while only minor sources are latched,
//   - dark otherwise.
//
// Ports
//   clk_20mhz      in   1          system clock
//   rst            in   1          synchronous reset, active-high
//   alarm_in       in   ALARM_NUM  raw alarm sources (asynchronous, active-high)
//   alarm_mask     in   ALARM_NUM  1 = source disabled (no new latch, not active)
//   alarm_clr      in   1          one-cycle pulse: clear latched alarms that
//                                  are no longer present
//   waring_led     out  1          panel alarm LED, active-low (0 = lit)
//   alarm_latched  out  ALARM_NUM  sticky alarm flags
//   alarm_active   out  1          any filtered, unmasked alarm present
//   alarm_cnt      out  8          saturating count of new-alarm events
// -----------------------------------------------------------------------------
module panel_alarm_ctr #(
    parameter int                   ALARM_NUM  = 4,
    parameter int                   FILT_CNT   = 200000,
    parameter int                   BLINK_HALF = 10000000,
    parameter logic [ALARM_NUM-1:0] CRIT_MASK  = ALARM_NUM'(1)
) (
    input  logic                 clk_20mhz,
    input  logic                 rst,
    input  logic [ALARM_NUM-1:0] alarm_in,
    input  logic [ALARM_NUM-1:0] alarm_mask,
    input  logic                 alarm_clr,
    output logic                 waring_led,
    output logic [ALARM_NUM-1:0] alarm_latched,
    output logic                 alarm_active,
    output logic [7:0]           alarm_cnt
);

    localparam int             FW        = $clog2(FILT_CNT);
    localparam logic [FW-1:0]  FILT_LAST = FW'(FILT_CNT - 1);
    localparam int             TW        = $clog2(2 * BLINK_HALF);
    localparam logic [TW-1:0]  TMR_LAST  = TW'(2 * BLINK_HALF - 1);
    localparam logic [TW-1:0]  TMR_HALF  = TW'(BLINK_HALF);

    typedef enum logic [1:0] {
        LED_OFF    = 2'd0,
        LED_STEADY = 2'd1,
        LED_BLINK  = 2'd2
    } led_state_t;

    logic [ALARM_NUM-1:0] filtered;

    // -------------------------------------------------------------------------
    // Per-source synchroniser and glitch filter. The filtered level only
    // follows the synchronised input after FILT_CNT consecutive cycles of
    // disagreement; any agreeing cycle restarts the count.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ALARM_NUM; gi++) begin : g_chan
            logic          sync1_reg;
            logic          sync2_reg;
            logic          filt_reg;
            logic [FW-1:0] filt_cnt_reg;

            always_ff @(posedge clk_20mhz) begin
                if (rst) begin
                    sync1_reg    <= 1'b0;
                    sync2_reg    <= 1'b0;
                    filt_reg     <= 1'b0;
                    filt_cnt_reg <= '0;
                end else begin
                    sync1_reg <= alarm_in[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg != filt_reg) begin
                        if (filt_cnt_reg == FILT_LAST) begin
                            filt_reg     <= sync2_reg;
                            filt_cnt_reg <= '0;
                        end else begin
                            filt_cnt_reg <= filt_cnt_reg + FW'(1);
                        end
                    end else begin
                        filt_cnt_reg <= '0;
                    end
                end
            end

            assign filtered[gi] = filt_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Latching, activity and event counting
    // -------------------------------------------------------------------------
    logic [ALARM_NUM-1:0] filtered_d_reg;
    logic [ALARM_NUM-1:0] latched_reg, latched_next;
    logic                 active_reg;
    logic [7:0]           cnt_reg, cnt_next;
    logic [ALARM_NUM-1:0] new_evt;
    logic [ALARM_NUM-1:0] present;
    logic [ALARM_NUM-1:0] clr_bits;

    always_comb begin
        new_evt  = filtered & ~filtered_d_reg & ~alarm_mask;
        present  = filtered & ~alarm_mask;
        // A clear only drops flags whose source has gone away (or is masked);
        // new events are OR-ed in afterwards so a same-cycle set always wins.
        clr_bits = alarm_clr ? ~present : '0;
        latched_next = (latched_reg & ~clr_bits) | new_evt;

        cnt_next = cnt_reg;
        if ((|new_evt) && (cnt_reg != 8'hFF)) begin
            cnt_next = cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk_20mhz) begin
        if (rst) begin
            filtered_d_reg <= '0;
            latched_reg    <= '0;
            active_reg     <= 1'b0;
            cnt_reg        <= 8'd0;
        end else begin
            filtered_d_reg <= filtered;
            latched_reg    <= latched_next;
            active_reg     <= |present;
            cnt_reg        <= cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // LED FSM and blink timer
    // -------------------------------------------------------------------------
    led_state_t    state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic          led_reg, led_next;

    always_comb begin
        state_next = LED_OFF;
        if (|(latched_reg & CRIT_MASK)) begin
            state_next = LED_STEADY;
        end else if (|latched_reg) begin
            state_next = LED_BLINK;
        end

        // Timer only runs while staying in BLINK; any entry into BLINK
        // starts from zero so the first half-period is lit.
        timer_next = '0;
        if ((state_next == LED_BLINK) && (state_reg == LED_BLINK)) begin
            timer_next = (timer_reg == TMR_LAST) ? '0 : timer_reg + TW'(1);
        end

        led_next = 1'b1;
        case (state_reg)
            LED_STEADY: led_next = 1'b0;
            LED_BLINK:  led_next = (timer_reg >= TMR_HALF);
            default:    led_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_20mhz) begin
        if (rst) begin
            state_reg <= LED_OFF;
            timer_reg <= '0;
            led_reg   <= 1'b1;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            led_reg   <= led_next;
        end
    end

    assign waring_led    = led_reg;
    assign alarm_latched = latched_reg;
    assign alarm_active  = active_reg;
    assign alarm_cnt     = cnt_reg;

endmodule
